// File: rtl/neuro_fixed_pkg.sv
// Shared Q14 fixed-point helpers and soma FSM state codes.
// Provides ONE/HALF constants, the soma state type and sat_add.
package neuro_fixed_pkg;

  localparam int Q_WIDTH = 18;
  localparam int Q_FRAC  = 14;

  localparam logic signed [Q_WIDTH-1:0] Q_ONE  = 18'sd16384;
  localparam logic signed [Q_WIDTH-1:0] Q_HALF = 18'sd8192;

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_BURST_WAIT = 2'd1,
    ST_REFRACT    = 2'd2
  } soma_state_e;

  // Add two signed values and clamp to a signed w-bit range.
  function automatic int sat_add(
    input int a,
    input int b,
    input int w
  );
    longint s;
    longint hi;
    longint lo;
    s  = longint'(a) + longint'(b);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return int'(s);
  endfunction

endpackage

// File: rtl/somatic_spike_generator_if.sv
// Bundle of soma inputs (drive, BAC, threshold, reset level, tick)
// and outputs (spike, burst, bAP, membrane, count, state).
interface somatic_spike_generator_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 16
);

  logic                    clk_en;
  logic signed [WIDTH-1:0] dendritic_input;
  logic                    bac_in;
  logic signed [WIDTH-1:0] v_threshold;
  logic signed [WIDTH-1:0] v_reset;

  logic                    spike_out;
  logic                    burst_active;
  logic                    bap_out;
  logic signed [WIDTH-1:0] v_mem;
  logic [CNT_W-1:0]        spike_count;
  logic [1:0]              state_out;

  modport master (
    output clk_en, dendritic_input, bac_in,
    output v_threshold, v_reset,
    input  spike_out, burst_active, bap_out,
    input  v_mem, spike_count, state_out
  );

  modport slave (
    input  clk_en, dendritic_input, bac_in,
    input  v_threshold, v_reset,
    output spike_out, burst_active, bap_out,
    output v_mem, spike_count, state_out
  );

endinterface

// File: rtl/soma_leak_integrator.sv
// Combinational leak step: v + ((drive - v) >>> TAU_SHIFT), saturated.
// Ports: v, drive (signed WIDTH) in; v_next (signed WIDTH) out.
module soma_leak_integrator
  import neuro_fixed_pkg::*;
#(
  parameter int WIDTH     = Q_WIDTH,
  parameter int TAU_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] drive,
  output logic signed [WIDTH-1:0] v_next
);

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] step;
  int                    sum;

  always_comb begin
    // One extra bit so drive - v never wraps.
    diff   = {drive[WIDTH-1], drive} - {v[WIDTH-1], v};
    step   = diff >>> TAU_SHIFT;
    sum    = sat_add(int'(v), int'(step), WIDTH);
    v_next = WIDTH'(sum);
  end

endmodule

// File: rtl/somatic_spike_generator.sv
// Axon-hillock soma: leaky integration, single spikes or BAC bursts,
// refractory hold and bAP flag. Ports: clk, rst, io (slave bundle).
module somatic_spike_generator
  import neuro_fixed_pkg::*;
#(
  parameter int WIDTH        = Q_WIDTH,
  parameter int FRAC         = Q_FRAC,
  parameter int TAU_SHIFT    = 3,
  parameter int BURST_LEN    = 3,
  parameter int BURST_ISI    = 2,
  parameter int REFRAC_TICKS = 8,
  parameter int BAP_TICKS    = 2,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  somatic_spike_generator_if.slave io
);

  if (FRAC >= WIDTH || BURST_LEN < 1 ||
      BURST_ISI < 1 || REFRAC_TICKS < 1 ||
      BAP_TICKS < 1) begin : g_bad_cfg
    $error("somatic_spike_generator: bad parameters");
  end

  localparam int RW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(BURST_ISI + 1);
  localparam int FW = $clog2(REFRAC_TICKS + 1);
  localparam int BW = $clog2(BAP_TICKS + 1);

  localparam logic [RW-1:0] REM_INIT = RW'(BURST_LEN - 1);
  localparam logic [IW-1:0] ISI_INIT = IW'(BURST_ISI);
  localparam logic [FW-1:0] REF_INIT = FW'(REFRAC_TICKS);
  localparam logic [BW-1:0] BAP_INIT = BW'(BAP_TICKS);

  soma_state_e             state_q, state_d;
  logic signed [WIDTH-1:0] v_mem_q, v_mem_d;
  logic [RW-1:0]           rem_q, rem_d;
  logic [IW-1:0]           isi_q, isi_d;
  logic [FW-1:0]           refrac_q, refrac_d;
  logic [BW-1:0]           bap_q, bap_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    burst_q, burst_d;
  logic                    spike_q, spike_d;
  logic                    fire;
  logic signed [WIDTH-1:0] v_next;

  soma_leak_integrator #(
    .WIDTH     (WIDTH),
    .TAU_SHIFT (TAU_SHIFT)
  ) u_leak (
    .v      (v_mem_q),
    .drive  (io.dendritic_input),
    .v_next (v_next)
  );

  always_comb begin
    state_d  = state_q;
    v_mem_d  = v_mem_q;
    rem_d    = rem_q;
    isi_d    = isi_q;
    refrac_d = refrac_q;
    bap_d    = bap_q;
    count_d  = count_q;
    burst_d  = burst_q;
    spike_d  = 1'b0;
    fire     = 1'b0;

    if (io.clk_en) begin
      if (bap_q != '0) bap_d = bap_q - 1'b1;

      unique case (state_q)
        ST_INTEGRATE: begin
          v_mem_d = v_next;
          if (v_next >= io.v_threshold) begin
            fire    = 1'b1;
            v_mem_d = io.v_reset;
            // bac_in matters only on the first spike.
            if (io.bac_in && BURST_LEN > 1) begin
              rem_d   = REM_INIT;
              isi_d   = ISI_INIT;
              burst_d = 1'b1;
              state_d = ST_BURST_WAIT;
            end else begin
              refrac_d = REF_INIT;
              state_d  = ST_REFRACT;
            end
          end
        end
        ST_BURST_WAIT: begin
          v_mem_d = io.v_reset;
          isi_d   = isi_q - 1'b1;
          if (isi_q == IW'(1)) begin
            fire  = 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == RW'(1)) begin
              burst_d  = 1'b0;
              refrac_d = REF_INIT;
              state_d  = ST_REFRACT;
            end else begin
              isi_d = ISI_INIT;
            end
          end
        end
        ST_REFRACT: begin
          v_mem_d  = io.v_reset;
          refrac_d = refrac_q - 1'b1;
          if (refrac_q == FW'(1)) state_d = ST_INTEGRATE;
        end
        default: state_d = ST_INTEGRATE;
      endcase

      if (fire) begin
        spike_d = 1'b1;
        count_d = count_q + 1'b1;
        bap_d   = BAP_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INTEGRATE;
      v_mem_q  <= '0;
      rem_q    <= '0;
      isi_q    <= '0;
      refrac_q <= '0;
      bap_q    <= '0;
      count_q  <= '0;
      burst_q  <= 1'b0;
      spike_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_mem_q  <= v_mem_d;
      rem_q    <= rem_d;
      isi_q    <= isi_d;
      refrac_q <= refrac_d;
      bap_q    <= bap_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      spike_q  <= spike_d;
    end
  end

  assign io.spike_out    = spike_q;
  assign io.burst_active = burst_q;
  assign io.bap_out      = (bap_q != '0);
  assign io.v_mem        = v_mem_q;
  assign io.spike_count  = count_q;
  assign io.state_out    = state_q;

endmodule

// File: tb/tb_somatic_spike_generator.sv
// Self-checking bench for somatic_spike_generator.
// Event-schedule reference model, directed and random ticks.
module tb_somatic_spike_generator;

  localparam int W   = 18;
  localparam int CW  = 16;
  localparam int TAU = 3;
  localparam int BL  = 3;
  localparam int BI  = 2;
  localparam int RT  = 8;
  localparam int BT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  somatic_spike_generator_if #(.WIDTH(W), .CNT_W(CW)) io ();

  somatic_spike_generator #(
    .WIDTH(W), .FRAC(14), .TAU_SHIFT(TAU),
    .BURST_LEN(BL), .BURST_ISI(BI),
    .REFRAC_TICKS(RT), .BAP_TICKS(BT), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: tick-indexed schedule of spikes and windows.
  int m_v, m_tick, m_blocked, m_bstart, m_blast;
  int m_last_spike, m_count;
  int m_q[$];
  bit m_fired;

  int obs[$];
  int bq[$];

  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int clampw(input int x);
    int hi;
    hi = (1 << (W - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi - 1;
    return x;
  endfunction

  task automatic model_reset();
    m_v = 0; m_tick = 0; m_blocked = 0;
    m_bstart = 0; m_blast = 0;
    m_last_spike = -1000; m_count = 0;
    m_q.delete();
    obs.delete();
    bq.delete();
  endtask

  task automatic model_tick(input int drive, input int thr,
                            input int vr, input bit bac);
    int nv;
    m_tick++;
    m_fired = 0;
    if (m_tick <= m_blocked) begin
      m_v = vr;
      if (m_q.size() > 0 && m_q[0] == m_tick) begin
        void'(m_q.pop_front());
        m_fired = 1;
      end
    end else begin
      nv = clampw(m_v + fdiv(drive - m_v, 1 << TAU));
      if (nv >= thr) begin
        m_fired  = 1;
        m_v      = vr;
        m_bstart = m_tick;
        m_blast  = m_tick;
        if (bac && BL > 1) begin
          for (int k = 1; k < BL; k++) m_q.push_back(m_tick + k * BI);
          m_blast = m_tick + (BL - 1) * BI;
        end
        m_blocked = m_blast + RT;
      end else begin
        m_v = nv;
      end
    end
    if (m_fired) begin
      m_count = (m_count + 1) % (1 << CW);
      m_last_spike = m_tick;
    end
  endtask

  task automatic tick(input int drive, input int thr,
                      input int vr, input bit bac);
    int exp_st;
    bit exp_burst, exp_bap;
    @(negedge clk);
    io.dendritic_input = W'(drive);
    io.v_threshold = W'(thr);
    io.v_reset = W'(vr);
    io.bac_in = bac;
    io.clk_en = 1'b1;
    @(posedge clk);
    #1;
    io.clk_en = 1'b0;
    model_tick(drive, thr, vr, bac);
    exp_st = (m_tick < m_blast) ? 1 : (m_tick < m_blocked) ? 2 : 0;
    exp_burst = (m_tick >= m_bstart) && (m_tick < m_blast);
    exp_bap = (m_tick <= m_last_spike + BT - 1);
    checks += 6;
    if (io.spike_out !== m_fired) begin
      errors++;
      $display("FAIL spike t=%0d got %b exp %b",
               m_tick, io.spike_out, m_fired);
    end
    if (io.v_mem !== m_v) begin
      errors++;
      $display("FAIL v_mem t=%0d got %0d exp %0d",
               m_tick, io.v_mem, m_v);
    end
    if (io.state_out !== exp_st) begin
      errors++;
      $display("FAIL state t=%0d got %0d exp %0d",
               m_tick, io.state_out, exp_st);
    end
    if (io.burst_active !== exp_burst) begin
      errors++;
      $display("FAIL burst t=%0d got %b exp %b",
               m_tick, io.burst_active, exp_burst);
    end
    if (io.bap_out !== exp_bap) begin
      errors++;
      $display("FAIL bap t=%0d got %b exp %b",
               m_tick, io.bap_out, exp_bap);
    end
    if (io.spike_count !== m_count) begin
      errors++;
      $display("FAIL count t=%0d got %0d exp %0d",
               m_tick, io.spike_count, m_count);
    end
    if (io.spike_out === 1'b1) obs.push_back(m_tick);
    if (io.burst_active === 1'b1) bq.push_back(m_tick);
    @(posedge clk);
    #1;
    checks++;
    if (io.spike_out !== 1'b0) begin
      errors++;
      $display("FAIL spike_fall t=%0d got %b exp 0",
               m_tick, io.spike_out);
    end
    repeat (9) @(posedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    io.clk_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_obs(input string nm, input int e0,
                           input int e1, input int e2);
    int e[3];
    e = '{e0, e1, e2};
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL %s n_spikes got %0d exp 3", nm, obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] != e[i]) begin
          errors++;
          $display("FAIL %s spike%0d tick got %0d exp %0d",
                   nm, i, obs[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (io.spike_out !== 1'b0) begin
      errors++; $display("FAIL rst spike got %b exp 0", io.spike_out);
    end
    if (io.burst_active !== 1'b0) begin
      errors++; $display("FAIL rst burst got %b exp 0", io.burst_active);
    end
    if (io.bap_out !== 1'b0) begin
      errors++; $display("FAIL rst bap got %b exp 0", io.bap_out);
    end
    if (io.v_mem !== 18'sd0) begin
      errors++; $display("FAIL rst v_mem got %0d exp 0", io.v_mem);
    end
    if (io.spike_count !== 16'd0) begin
      errors++; $display("FAIL rst count got %0d exp 0", io.spike_count);
    end
    if (io.state_out !== 2'd0) begin
      errors++; $display("FAIL rst state got %0d exp 0", io.state_out);
    end
  endtask

  task automatic test_single_spikes();
    apply_reset();
    for (int t = 1; t <= 40; t++) tick(16384, 8192, 0, 1'b0);
    check_obs("single", 6, 20, 34);
    checks++;
    if (bq.size() != 0) begin
      errors++;
      $display("FAIL single burst_ticks got %0d exp 0", bq.size());
    end
  endtask

  task automatic test_bac_burst();
    apply_reset();
    for (int t = 1; t <= 18; t++) tick(16384, 8192, 0, 1'b1);
    check_obs("burst", 6, 8, 10);
    checks += 2;
    if (io.spike_count !== 16'd3) begin
      errors++;
      $display("FAIL burst count got %0d exp 3", io.spike_count);
    end
    if (bq.size() != 4) begin
      errors++;
      $display("FAIL burst high_ticks got %0d exp 4", bq.size());
    end else begin
      checks += 2;
      if (bq[0] != 6) begin
        errors++; $display("FAIL burst rise got %0d exp 6", bq[0]);
      end
      if (bq[3] != 9) begin
        errors++; $display("FAIL burst last_high got %0d exp 9", bq[3]);
      end
    end
  endtask

  task automatic test_bac_drop();
    apply_reset();
    for (int t = 1; t <= 18; t++)
      tick(16384, 8192, 0, (t < 7) ? 1'b1 : 1'b0);
    check_obs("bac_drop", 6, 8, 10);
  endtask

  task automatic test_subthreshold();
    int v;
    apply_reset();
    for (int t = 1; t <= 200; t++) tick(4096, 8192, 0, 1'b0);
    v = io.v_mem;
    checks += 2;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL subthr spikes got %0d exp 0", obs.size());
    end
    if (v < 4096 - 8 || v > 4096 + 8) begin
      errors++;
      $display("FAIL subthr settle got %0d exp 4096+-8", v);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int t = 1; t <= 8; t++) tick(16384, 8192, 0, 1'b1);
    checks++;
    if (io.burst_active !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre_burst got %b exp 1", io.burst_active);
    end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (io.burst_active !== 1'b0) begin
      errors++; $display("FAIL midrst burst got %b exp 0", io.burst_active);
    end
    if (io.bap_out !== 1'b0) begin
      errors++; $display("FAIL midrst bap got %b exp 0", io.bap_out);
    end
    if (io.state_out !== 2'd0) begin
      errors++; $display("FAIL midrst state got %0d exp 0", io.state_out);
    end
    if (io.spike_count !== 16'd0) begin
      errors++; $display("FAIL midrst count got %0d exp 0", io.spike_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int t = 1; t <= 8; t++) tick(16384, 8192, 0, 1'b1);
    checks++;
    if (obs.size() == 0 || obs[0] != 6) begin
      errors++;
      $display("FAIL midrst first_spike got %0d exp 6",
               (obs.size() == 0) ? -1 : obs[0]);
    end
  endtask

  task automatic test_random();
    int drive, thr, vr;
    bit bac;
    apply_reset();
    drive = 20000; thr = 9000; vr = 0;
    for (int t = 1; t <= 400; t++) begin
      if ($urandom_range(0, 19) == 0) begin
        drive = int'($urandom_range(0, 60000)) - 20000;
        thr = int'($urandom_range(2000, 30000));
        vr = int'($urandom_range(0, 12000)) - 8000;
      end
      bac = 1'($urandom_range(0, 1));
      tick(drive, thr, vr, bac);
    end
  endtask

  initial begin
    io.clk_en = 1'b0;
    io.dendritic_input = '0;
    io.bac_in = 1'b0;
    io.v_threshold = '0;
    io.v_reset = '0;
    model_reset();
    test_reset();
    test_single_spikes();
    test_bac_burst();
    test_bac_drop();
    test_subthreshold();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
